// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and 7-segment patterns for the intersection display blocks.
// Pure definitions: no latency, no flow control.
// seg_decode blanks any non-decimal nibble.
package traffic_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t GR = 3'd3;
    localparam phase_t YR = 3'd4;
    localparam phase_t RG = 3'd5;
    localparam phase_t RY = 3'd6;

    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_RED = 3'b100;
    localparam lamp_t LAMP_YEL = 3'b010;
    localparam lamp_t LAMP_GRN = 3'b001;
    localparam lamp_t LAMP_OFF = 3'b000;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic is_phase(input phase_t p);
        is_phase = (p == GR) || (p == YR) || (p == RG) || (p == RY);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 2-digit BCD converter (shift-add-3), one iteration per cycle.
// Latency: start + 7 iterations; bcd is valid the cycle after done.
// No backpressure: start restarts the conversion, reset aborts it.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd
);
    logic [6:0] shreg;
    logic [2:0] iter;
    logic [7:0] adj;

    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    // done marks the cycle that performs the final iteration
    assign done = busy && (iter == 3'd6);

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            iter  <= 3'd0;
            shreg <= 7'd0;
            bcd   <= 8'd0;
        end else if (start) begin
            busy  <= 1'b1;
            iter  <= 3'd0;
            shreg <= bin;
            bcd   <= 8'd0;
        end else if (busy) begin
            {bcd, shreg} <= {adj, shreg} << 1;
            iter         <= iter + 3'd1;
            if (iter == 3'd6) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_display_driver.sv
// Drives both lane lamp heads and a 4-digit multiplexed 7-segment countdown panel.
// Latency: lamps 1 cycle from state; display refreshed every 9 cycles.
// No backpressure: inputs are sampled freely, changes mid-conversion wait for the next capture.
module lane_display_driver
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic [6:0] timeLane1,
    input  logic [6:0] timeLane2,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic [6:0] seg,
    output logic [3:0] digit_sel,
    output logic       conv_busy
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    fsm;
    phase_t        snap_state;
    logic [7:0]    disp1, disp2, bcd1, bcd2;
    logic [7:0]    disp1_nx, disp2_nx;
    logic [6:0]    t1_clamp, t2_clamp;
    logic          busy1, busy2, done1, done2, start;
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic [1:0]    idx, idx_nx;
    logic [3:0]    nib;
    logic          is_tens;
    logic [6:0]    seg_nx;

    assign t1_clamp  = (timeLane1 > 7'd99) ? 7'd99 : timeLane1;
    assign t2_clamp  = (timeLane2 > 7'd99) ? 7'd99 : timeLane2;
    assign start     = (fsm == ST_IDLE);
    assign conv_busy = busy1 | busy2;

    bin2bcd_seq u_bcd1 (.clk(clk), .reset(reset), .start(start), .bin(t1_clamp),
                        .busy(busy1), .done(done1), .bcd(bcd1));
    bin2bcd_seq u_bcd2 (.clk(clk), .reset(reset), .start(start), .bin(t2_clamp),
                        .busy(busy2), .done(done2), .bcd(bcd2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm        <= ST_IDLE;
            snap_state <= 3'd0;
            disp1      <= 8'd0;
            disp2      <= 8'd0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    snap_state <= state;
                    fsm        <= ST_CONV;
                end
                ST_CONV: if (done1 && done2) fsm <= ST_DONE;
                ST_DONE: begin
                    disp1 <= bcd1;
                    disp2 <= bcd2;
                    fsm   <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // seg is decoded from next-cycle display/index so a DONE load and a scan step never tear
    always_comb begin
        disp1_nx = disp1;
        disp2_nx = disp2;
        if (fsm == ST_DONE) begin
            disp1_nx = bcd1;
            disp2_nx = bcd2;
        end
        idx_nx = (scan_cnt == SCAN_LAST) ? idx + 2'd1 : idx;
        case (idx_nx)
            2'd0:    nib = disp1_nx[7:4];
            2'd1:    nib = disp1_nx[3:0];
            2'd2:    nib = disp2_nx[7:4];
            default: nib = disp2_nx[3:0];
        endcase
        is_tens = ~idx_nx[0];
        if (!is_phase(snap_state) || (is_tens && nib == 4'd0)) seg_nx = SEG_BLANK;
        else                                                   seg_nx = seg_decode(nib);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            digit_sel <= 4'b0001;
            seg       <= SEG_BLANK;
        end else begin
            scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
            idx       <= idx_nx;
            digit_sel <= 4'b0001 << idx_nx;
            seg       <= seg_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
            lamp1     <= LAMP_RED;
            lamp2     <= LAMP_RED;
        end else begin
            blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
            if (blink_cnt == BLINK_LAST) blink <= ~blink;
            case (state)
                GR:      begin lamp1 <= LAMP_GRN; lamp2 <= LAMP_RED; end
                YR:      begin lamp1 <= LAMP_YEL; lamp2 <= LAMP_RED; end
                RG:      begin lamp1 <= LAMP_RED; lamp2 <= LAMP_GRN; end
                RY:      begin lamp1 <= LAMP_RED; lamp2 <= LAMP_YEL; end
                default: begin lamp1 <= {1'b0, blink, 1'b0}; lamp2 <= {1'b0, blink, 1'b0}; end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_display_driver.sv
// Directed bench for lane_display_driver with SCAN_DIV=4, BLINK_DIV=5.
module tb_lane_display_driver;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic [6:0] timeLane1, timeLane2;
    logic [2:0] lamp1, lamp2;
    logic [6:0] seg;
    logic [3:0] digit_sel;
    logic       conv_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lane_display_driver #(.SCAN_DIV(4), .BLINK_DIV(5)) dut (
        .clk(clk), .reset(reset), .state(state),
        .timeLane1(timeLane1), .timeLane2(timeLane2),
        .lamp1(lamp1), .lamp2(lamp2), .seg(seg),
        .digit_sel(digit_sel), .conv_busy(conv_busy)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_sel(input logic [3:0] target, input logic want_eq, input string tag);
        int k = 0;
        while (((digit_sel == target) != want_eq) && k < 64) begin
            step();
            k++;
        end
        chk(tag, 32'(k < 64), 32'd1);
    endtask

    task automatic wait_lamp(input logic [2:0] target, input string tag);
        int k = 0;
        while (lamp1 != target && k < 40) begin
            step();
            k++;
        end
        chk(tag, 32'(k < 40), 32'd1);
    endtask

    // Align to the start of digit 0, then check a full 16-cycle scan.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e [4];
        e = '{e0, e1, e2, e3};
        wait_sel(4'b1000, 1'b1, {tag, " align1"});
        wait_sel(4'b1000, 1'b0, {tag, " align2"});
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s sel d%0d c%0d", tag, d, k), 32'(digit_sel), 32'(4'b0001 << d));
                chk($sformatf("%s seg d%0d c%0d", tag, d, k), 32'(seg), 32'(e[d]));
                step();
            end
        end
        chk({tag, " sel wrap"}, 32'(digit_sel), 32'h1);
    endtask

    initial begin
        reset     = 1'b0;
        state     = GR;
        timeLane1 = 7'd25;
        timeLane2 = 7'd30;

        // 1: reset values, then first lamp update
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst lamp1", 32'(lamp1), 32'h4);
            chk("rst lamp2", 32'(lamp2), 32'h4);
            chk("rst seg", 32'(seg), 32'h0);
            chk("rst sel", 32'(digit_sel), 32'h1);
            chk("rst busy", 32'(conv_busy), 32'h0);
        end
        reset = 1'b1;
        step();
        chk("rel lamp1", 32'(lamp1), 32'h1);
        chk("rel lamp2", 32'(lamp2), 32'h4);

        // 2: 7 / 42, tens blank on lane 1
        timeLane1 = 7'd7;
        timeLane2 = 7'd42;
        step(20);
        scan_check("t7_42", 7'h00, 7'h07, 7'h66, 7'h5B);

        // 3: clamping above 99, exact 100 too
        timeLane1 = 7'd120;
        timeLane2 = 7'd100;
        step(20);
        scan_check("clamp", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        // units zero always shown, tens zero blanked
        timeLane1 = 7'd10;
        timeLane2 = 7'd0;
        step(20);
        scan_check("zeros", 7'h06, 7'h3F, 7'h00, 7'h3F);

        // 4: phase sequence
        state = YR; step();
        chk("YR lamp1", 32'(lamp1), 32'h2);
        chk("YR lamp2", 32'(lamp2), 32'h4);
        state = RG; step();
        chk("RG lamp1", 32'(lamp1), 32'h4);
        chk("RG lamp2", 32'(lamp2), 32'h1);
        state = RY; step();
        chk("RY lamp1", 32'(lamp1), 32'h4);
        chk("RY lamp2", 32'(lamp2), 32'h2);
        state = GR; step();
        chk("GR lamp1", 32'(lamp1), 32'h1);
        chk("GR lamp2", 32'(lamp2), 32'h4);

        // 5: fault blink and blanked panel
        state = 3'd0;
        wait_lamp(3'b000, "blink low");
        wait_lamp(3'b010, "blink high");
        for (int i = 0; i < 5; i++) begin
            chk("blink on l1", 32'(lamp1), 32'h2);
            chk("blink on l2", 32'(lamp2), 32'h2);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("blink off l1", 32'(lamp1), 32'h0);
            chk("blink off l2", 32'(lamp2), 32'h0);
            step();
        end
        chk("blink again", 32'(lamp1), 32'h2);
        step(20);
        scan_check("fault", 7'h00, 7'h00, 7'h00, 7'h00);

        // 6: reset during the 4th conversion iteration
        state = GR;
        begin
            int k = 0;
            while (conv_busy && k < 20) begin step(); k++; end
            while (!conv_busy && k < 20) begin step(); k++; end
            chk("busy found", 32'(k < 20), 32'd1);
        end
        step(3);
        reset     = 1'b0;
        state     = RG;
        timeLane1 = 7'd58;
        timeLane2 = 7'd36;
        step();
        chk("mid rst busy", 32'(conv_busy), 32'h0);
        chk("mid rst seg", 32'(seg), 32'h0);
        chk("mid rst sel", 32'(digit_sel), 32'h1);
        chk("mid rst lamp1", 32'(lamp1), 32'h4);
        step();
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k <= 7) chk($sformatf("post busy c%0d", k), 32'(conv_busy), 32'h1);
        end
        // the loop above leaves us at cycle 9; re-check cycles 8/9 explicitly below
        chk("post c9 busy", 32'(conv_busy), 32'h0);
        chk("post c9 sel", 32'(digit_sel), 32'h4);
        chk("post c9 seg", 32'(seg), 32'h4F);
        chk("post lamp2", 32'(lamp2), 32'h1);
        step(20);
        scan_check("t58_36", 7'h6D, 7'h7F, 7'h4F, 7'h7D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // cycle 8 after release: conversion finished, display not yet loaded
    initial begin : c8_probe
        @(posedge reset);
        @(posedge reset);
        repeat (8) @(posedge clk);
        #1;
        chk("post c8 busy", 32'(conv_busy), 32'h0);
        chk("post c8 sel", 32'(digit_sel), 32'h4);
        chk("post c8 seg", 32'(seg), 32'h0);
    end

endmodule

// File: doc/lane_display_driver.md
Name: lane_display_driver

Overview:
Downstream consumer of the auto-mode sequencer. Takes the sequencer's phase code and the two per-lane countdowns, and drives the physical lamp heads of both lanes. Also drives a 4-digit multiplexed 7-segment panel showing each lane's remaining seconds as two decimal digits. Binary-to-BCD conversion is sequential (shift-add-3), so the block is fully clocked.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays selected before the scan advances (min 2)
BLINK_DIV, 50000, clk cycles per half-period of the fault blink (min 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
state  input  3  phase code from sequencer: GR=3, YR=4, RG=5, RY=6; any other value = fault/idle
timeLane1  input  7  lane-1 remaining seconds, unsigned
timeLane2  input  7  lane-2 remaining seconds, unsigned
lamp1  output  3  lane-1 head, [2]=red [1]=yellow [0]=green, active-high
lamp2  output  3  lane-2 head, same encoding
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high
digit_sel  output  4  one-hot digit enable: [0]=L1 tens, [1]=L1 units, [2]=L2 tens, [3]=L2 units
conv_busy  output  1  high while a BCD conversion is in progress

Behaviour:
- Reset (reset==0 at posedge clk) values:
  - lamp1 = lamp2 = 3'b100 (all red); seg = 0; digit_sel = 4'b0001; conv_busy = 0.
  - Scan counter, blink counter, blink flag, digit index and BCD display registers all cleared.
  - FSM forced to IDLE; any conversion in flight is aborted and its partial result discarded.
- Lamp path, registered with 1-cycle latency from state:
  - GR: lamp1 = 001, lamp2 = 100.
  - YR: lamp1 = 010, lamp2 = 100.
  - RG: lamp1 = 100, lamp2 = 001.
  - RY: lamp1 = 100, lamp2 = 010.
  - Any other code: both lamps = {0, blink, 0}.
- Conversion FSM, states IDLE -> CONV -> DONE -> IDLE:
  - IDLE: capture timeLane1, timeLane2 and state into snapshot registers. Each time is clamped to 99 if above 99. Go to CONV; conv_busy = 1 from the next cycle.
  - CONV: 7 iterations of add-3-if-≥5 then shift, run in parallel for both lanes. A 3-bit iteration counter exits after iteration 7.
  - DONE: load the 8-bit BCD result of each lane into its display register. conv_busy = 0. Return to IDLE.
  - Period is 9 cycles. The display reflects inputs sampled at most 9 cycles earlier and is never torn mid-update.
  - Input changes during CONV are ignored until the next IDLE capture.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0->1->2->3->0 and digit_sel/seg update in the same cycle.
  - seg is the registered decode of the selected BCD nibble: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Leading-zero blanking: a tens digit of 0 gives seg = 0. A units digit of 0 always shows 3F.
  - Snapshot state code not in {3,4,5,6]: seg = 0 for all digits; the scan keeps running.
- Blink: counter counts 0..BLINK_DIV-1; the blink flag toggles on each wrap.
- Simultaneous events: a DONE update and a scan advance in the same cycle use the new display value.

Decomposition:
- Package traffic_pkg holds:
  - Phase constants GR/YR/RG/RY and the 3-bit state type.
  - Lamp encodings LAMP_RED/LAMP_YEL/LAMP_GRN/LAMP_OFF.
  - 7-segment pattern constants, plus a function seg_decode(bcd) used here and by future display blocks.
- One sub-module, bin2bcd_seq:
  - Start/busy/done handshake; 7-bit in, 8-bit BCD out, 7 iterations.
  - Instantiated twice, one per lane, sharing the FSM's start.

Test Plan:
1. Reset held low 3 cycles, with state=GR and times at 25/30, then released -> during reset lamps = 100/100, seg=0, digit_sel=0001; 1 cycle after release lamp1=001, lamp2=100.
2. state=GR, timeLane1=7, timeLane2=42, SCAN_DIV=4 -> within 9 cycles the display registers hold 0x07/0x42; the scan shows seg 00,07,66,5B on digit_sel 0001,0010,0100,1000, 4 cycles each.
3. timeLane1=120 -> clamped; digits show 9 and 9 (6F,6F).
4. state sequence GR->YR->RG->RY -> lamp1/lamp2 = 001/100, 010/100, 100/001, 100/010, each 1 cycle after the input change.
5. state=0, BLINK_DIV=5 -> both lamps alternate 010/000 every 5 cycles; seg=0 on all digits.
6. Reset asserted mid-CONV (cycle 4 of 7) -> conv_busy=0 and display registers =0 after reset. After release, first valid update 9 cycles later with the new inputs.
